// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline control path:
//   - RV32 opcode constants for the supported instruction classes
//   - ALUOp encodings consumed by the EX-stage ALU control decoder
//   - ctrl_word_t, the packed control word carried by ID/EX and later
//     stage registers
package pipe_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       fun7;
    logic [2:0] fun3;
  } ctrl_word_t;

endpackage

// File: rtl/id_ex_ctrl_stage_imm_gen.sv
// imm_gen
//   Combinational immediate generator. Selects the immediate format from
//   the opcode and sign-extends it to XLEN.
//   Ports:
//     instr  in   32    instruction word
//     imm    out  XLEN  sign-extended immediate (0 for R-type / unknown)
module imm_gen
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  // I-type covers both ALU-immediate and loads; S and B split their
  // immediates around the rd field. B immediates are always even.
  always_comb begin
    imm = '0;
    case (instr[6:0])
      OP_IMM, OP_LOAD:
        imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      OP_STORE:
        imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:
        imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
               instr[11:8], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// id_ex_ctrl_stage
//   Decodes the IF/ID instruction into the main control word, generates the
//   immediate, detects load-use hazards and registers everything into the
//   ID/EX pipeline register.
//   Optional feature macro: ID_ILLEGAL_TRAP_EN
//     defined   : unsupported valid opcodes enter EX as a valid bubble with
//                 ex_illegal=1 so a later stage can trap
//     undefined : unsupported opcodes become plain bubbles, ex_illegal=0
//   Ports:
//     clk, rst              clock, synchronous active-high reset
//     if_id_valid/instr/pc  instruction presented by IF/ID
//     ex_stall              EX cannot accept; ID/EX holds
//     flush                 taken branch in EX; squash ID
//     id_stall              hold PC and IF/ID this cycle (combinational)
//     ex_*                  registered ID/EX contents
module id_ex_ctrl_stage
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_id_valid,
  input  logic [31:0]     if_id_instr,
  input  logic [XLEN-1:0] if_id_pc,
  input  logic            ex_stall,
  input  logic            flush,
  output logic            id_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_alu_src,
  output logic            ex_branch,
  output logic [1:0]      ex_alu_op,
  output logic            ex_fun7,
  output logic [2:0]      ex_fun3,
  output logic            ex_illegal
);

  logic [6:0]      opcode;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] dec_imm;
  ctrl_word_t      dec_ctrl;
  ctrl_word_t      ex_ctrl;
  logic            dec_supported;
  logic            rs2_used;
  logic            load_use;
  logic            load_valid;

  assign opcode = if_id_instr[6:0];
  assign rd     = if_id_instr[11:7];
  assign rs1    = if_id_instr[19:15];
  assign rs2    = if_id_instr[24:20];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (if_id_instr),
    .imm   (dec_imm)
  );

  // Main control decode. Unknown opcodes leave the word all-zero and
  // report themselves as unsupported (which also means no register use).
  always_comb begin
    dec_ctrl      = '0;
    dec_supported = 1'b1;
    rs2_used      = 1'b0;
    case (opcode)
      OP_R: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = ALUOP_R;
        dec_ctrl.fun7      = if_id_instr[30];
        dec_ctrl.fun3      = if_id_instr[14:12];
        rs2_used           = 1'b1;
      end
      OP_IMM: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALUOP_I;
        dec_ctrl.fun3      = if_id_instr[14:12];
      end
      OP_LOAD: begin
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.alu_op     = ALUOP_MEM;
        dec_ctrl.fun3       = if_id_instr[14:12];
      end
      OP_STORE: begin
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALUOP_MEM;
        dec_ctrl.fun3      = if_id_instr[14:12];
        rs2_used           = 1'b1;
      end
      OP_BRANCH: begin
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = ALUOP_BR;
        dec_ctrl.fun3   = if_id_instr[14:12];
        rs2_used        = 1'b1;
      end
      default: begin
        dec_supported = 1'b0;
      end
    endcase
  end

  // A load in EX whose destination feeds the instruction in ID must wait
  // one cycle; x0 never creates a dependency.
  assign load_use = if_id_valid & ex_valid & ex_ctrl.mem_read &
                    (ex_rd != 5'd0) &
                    ((dec_supported & (ex_rd == rs1)) |
                     (rs2_used & (ex_rd == rs2)));

  // A flush squashes ID, so nothing upstream needs to be held.
  assign id_stall = ~flush & (ex_stall | load_use);

`ifdef ID_ILLEGAL_TRAP_EN
  logic illegal_q;
  logic load_illegal;
  assign load_valid   = if_id_valid;
  assign load_illegal = if_id_valid & ~dec_supported;
  assign ex_illegal   = illegal_q;
`else
  assign load_valid   = if_id_valid & dec_supported;
  assign ex_illegal   = 1'b0;
`endif

  // ID/EX register. Priority: reset, flush, EX stall (hold), load-use
  // bubble, normal load. Bubbles clear every field so the register
  // contents stay deterministic.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_pc    <= '0;
      ex_imm   <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
`ifdef ID_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else if (!ex_stall) begin
      if (load_use) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
        ex_pc    <= '0;
        ex_imm   <= '0;
        ex_rs1   <= '0;
        ex_rs2   <= '0;
        ex_rd    <= '0;
`ifdef ID_ILLEGAL_TRAP_EN
        illegal_q <= 1'b0;
`endif
      end else begin
        ex_valid <= load_valid;
        ex_ctrl  <= if_id_valid ? dec_ctrl : '0;
        ex_pc    <= if_id_pc;
        ex_imm   <= dec_imm;
        ex_rs1   <= rs1;
        ex_rs2   <= rs2;
        ex_rd    <= rd;
`ifdef ID_ILLEGAL_TRAP_EN
        illegal_q <= load_illegal;
`endif
      end
    end
  end

  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_branch     = ex_ctrl.branch;
  assign ex_alu_op     = ex_ctrl.alu_op;
  assign ex_fun7       = ex_ctrl.fun7;
  assign ex_fun3       = ex_ctrl.fun3;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// tb_id_ex_ctrl_stage
//   Self-checking bench for id_ex_ctrl_stage: directed test-plan steps
//   followed by randomized traffic, all compared against a table-driven
//   reference model of the ID/EX register. Honours ID_ILLEGAL_TRAP_EN.
module tb_id_ex_ctrl_stage;

`ifdef ID_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        ex_stall;
  logic        flush;
  logic        id_stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        ex_alu_src;
  logic        ex_branch;
  logic [1:0]  ex_alu_op;
  logic        ex_fun7;
  logic [2:0]  ex_fun3;
  logic        ex_illegal;

  id_ex_ctrl_stage #(.XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .ex_stall      (ex_stall),
    .flush         (flush),
    .id_stall      (id_stall),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .ex_imm        (ex_imm),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_alu_src    (ex_alu_src),
    .ex_branch     (ex_branch),
    .ex_alu_op     (ex_alu_op),
    .ex_fun7       (ex_fun7),
    .ex_fun3       (ex_fun3),
    .ex_illegal    (ex_illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instruction classes: 0 unsupported, 1 R, 2 I-ALU, 3 load, 4 store, 5 branch.
  // Control table rows: {reg_write, mem_read, mem_write, mem_to_reg,
  // alu_src, branch, alu_op[1:0]}.
  logic [7:0] ctrl_tab [0:5] = '{8'h00, 8'h82, 8'h8B, 8'hD8, 8'h28, 8'h05};

  // Reference model of the ID/EX register contents.
  bit          m_valid;
  bit          m_ill;
  logic [7:0]  m_ctrl;
  bit          m_f7;
  logic [2:0]  m_f3;
  logic [31:0] m_pc;
  logic [31:0] m_imm;
  logic [4:0]  m_rs1;
  logic [4:0]  m_rs2;
  logic [4:0]  m_rd;
  bit          m_ctrl_known;
  bit          m_data_known;
  bit          last_stall;

  function automatic int kind_of(input logic [31:0] ins);
    case (ins[6:0])
      7'h33:   return 1;
      7'h13:   return 2;
      7'h03:   return 3;
      7'h23:   return 4;
      7'h63:   return 5;
      default: return 0;
    endcase
  endfunction

  // Immediate computed with signed shifts on the whole word.
  function automatic logic [31:0] imm_of(input logic [31:0] ins);
    int s;
    int k;
    s = $signed(ins);
    k = kind_of(ins);
    if (k == 2 || k == 3) return 32'(s >>> 20);
    if (k == 4) return 32'(((s >>> 25) * 32) + int'(ins[11:7]));
    if (k == 5) return 32'(((s >>> 31) * 4096) + int'(ins[7]) * 2048 +
                           int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2);
    return 32'h0;
  endfunction

  function automatic bit model_load_use(input bit v, input logic [31:0] ins);
    int k;
    bit uses1;
    bit uses2;
    k = kind_of(ins);
    uses1 = (k != 0);
    uses2 = (k == 1 || k == 4 || k == 5);
    if (!(v && m_valid && m_ctrl[6] && m_rd != 5'd0)) return 1'b0;
    return (uses1 && m_rd == ins[19:15]) || (uses2 && m_rd == ins[24:20]);
  endfunction

  task automatic model_bubble(input bit data_zero);
    m_valid = 1'b0; m_ill = 1'b0; m_ctrl = 8'h00; m_f7 = 1'b0; m_f3 = 3'd0;
    m_ctrl_known = 1'b1;
    m_data_known = data_zero;
    if (data_zero) begin
      m_pc = '0; m_imm = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
    end
  endtask

  task automatic model_update(input bit v, input logic [31:0] ins,
                              input logic [31:0] p, input bit st,
                              input bit fl, input bit r, input bit lu);
    int k;
    k = kind_of(ins);
    if (r) model_bubble(1'b1);
    else if (fl) model_bubble(1'b0);
    else if (st) begin end
    else if (lu) model_bubble(1'b0);
    else if (!v) begin
      m_valid = 1'b0; m_ill = 1'b0;
      m_ctrl_known = 1'b0; m_data_known = 1'b0;
    end else if (k == 0) begin
      model_bubble(1'b0);
      m_valid = TRAP_EN;
      m_ill   = TRAP_EN;
    end else begin
      m_valid = 1'b1; m_ill = 1'b0;
      m_ctrl = ctrl_tab[k];
      m_f7 = (k == 1) ? ins[30] : 1'b0;
      m_f3 = ins[14:12];
      m_pc = p; m_imm = imm_of(ins);
      m_rs1 = ins[19:15]; m_rs2 = ins[24:20]; m_rd = ins[11:7];
      m_ctrl_known = 1'b1; m_data_known = 1'b1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkState();
    checkOutput("ex_valid", 32'(ex_valid), 32'(m_valid));
    checkOutput("ex_illegal", 32'(ex_illegal), 32'(m_ill));
    if (m_ctrl_known) begin
      checkOutput("ctrl_word", 32'({ex_reg_write, ex_mem_read, ex_mem_write,
                  ex_mem_to_reg, ex_alu_src, ex_branch, ex_alu_op}), 32'(m_ctrl));
      checkOutput("ex_fun7", 32'(ex_fun7), 32'(m_f7));
      checkOutput("ex_fun3", 32'(ex_fun3), 32'(m_f3));
    end
    if (m_data_known) begin
      checkOutput("ex_pc", ex_pc, m_pc);
      checkOutput("ex_imm", ex_imm, m_imm);
      checkOutput("ex_regs", 32'({ex_rs1, ex_rs2, ex_rd}), 32'({m_rs1, m_rs2, m_rd}));
    end
  endtask

  // Drive one cycle: check combinational id_stall before the edge, then
  // advance the model and check the registered outputs after it.
  task automatic applyStimulus(input bit v, input logic [31:0] ins,
                               input logic [31:0] p, input bit st,
                               input bit fl, input bit r);
    bit lu;
    bit exp_stall;
    @(negedge clk);
    if_id_valid = v; if_id_instr = ins; if_id_pc = p;
    ex_stall = st; flush = fl; rst = r;
    #1;
    lu = model_load_use(v, ins);
    exp_stall = !fl && (st || lu);
    checkOutput("id_stall", 32'(id_stall), 32'(exp_stall));
    last_stall = exp_stall;
    @(posedge clk);
    model_update(v, ins, p, st, fl, r, lu);
    #1;
    checkState();
  endtask

  function automatic logic [31:0] gen_instr();
    logic [6:0] ops [0:5] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h7F};
    logic [6:0] top7;
    logic [2:0] f3;
    logic [4:0] a, b, d;
    top7 = 7'($urandom);
    f3   = 3'($urandom);
    a    = 5'($urandom_range(0, 3));
    b    = 5'($urandom_range(0, 3));
    d    = 5'($urandom_range(0, 3));
    return {top7, b, a, f3, d, ops[$urandom_range(0, 5)]};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] cur;
    bit fl_prev;
    rst = 1'b1; if_id_valid = 1'b0; if_id_instr = '0; if_id_pc = '0;
    ex_stall = 1'b0; flush = 1'b0;
    model_bubble(1'b1);
    last_stall = 1'b0;

    // Reset: everything zero.
    applyStimulus(0, 32'h0, 32'h0, 0, 0, 1);
    applyStimulus(0, 32'h0, 32'h0, 0, 0, 1);
    checkOutput("reset_id_stall", 32'(id_stall), 32'h0);

    // add x3,x1,x2
    applyStimulus(1, 32'h002081B3, 32'h100, 0, 0, 0);
    checkOutput("add_alu_op", 32'(ex_alu_op), 32'h2);
    checkOutput("add_rd", 32'(ex_rd), 32'h3);
    // sub x3,x1,x2
    applyStimulus(1, 32'h402081B3, 32'h104, 0, 0, 0);
    checkOutput("sub_fun7", 32'(ex_fun7), 32'h1);

    // lw x5,8(x1) then dependent add x6,x5,x2
    applyStimulus(1, 32'h0080A283, 32'h108, 0, 0, 0);
    applyStimulus(1, 32'h00228333, 32'h10C, 0, 0, 0);
    checkOutput("lu_bubble_valid", 32'(ex_valid), 32'h0);
    applyStimulus(1, 32'h00228333, 32'h10C, 0, 0, 0);
    checkOutput("lu_add_rs1", 32'(ex_rs1), 32'h5);
    checkOutput("lu_add_valid", 32'(ex_valid), 32'h1);

    // sw x2,-4(x1)
    applyStimulus(1, 32'hFE20AE23, 32'h110, 0, 0, 0);
    checkOutput("sw_imm", ex_imm, 32'hFFFFFFFC);
    checkOutput("sw_mem_write", 32'(ex_mem_write), 32'h1);

    // add held by ex_stall for 3 cycles, then flush with stall
    applyStimulus(1, 32'h002081B3, 32'h114, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 32'h402081B3, 32'h118, 1, 0, 0);
    checkOutput("hold_pc", ex_pc, 32'h114);
    applyStimulus(1, 32'h402081B3, 32'h118, 1, 1, 0);
    checkOutput("flush_valid", 32'(ex_valid), 32'h0);

    // Unsupported opcode
    applyStimulus(1, 32'h0000007F, 32'h11C, 0, 0, 0);
    checkOutput("illegal_valid", 32'(ex_valid), 32'(TRAP_EN));
    checkOutput("illegal_flag", 32'(ex_illegal), 32'(TRAP_EN));

    // Reset during a load-use stall
    applyStimulus(1, 32'h0080A283, 32'h120, 0, 0, 0);
    applyStimulus(1, 32'h00228333, 32'h124, 0, 0, 1);
    checkOutput("rst_stall_drop", 32'(id_stall), 32'h0);

    // Flush together with load-use
    applyStimulus(1, 32'h0080A283, 32'h128, 0, 0, 0);
    applyStimulus(1, 32'h00228333, 32'h12C, 0, 1, 0);

    // Randomized traffic
    cur = gen_instr();
    fl_prev = 1'b0;
    for (int n = 0; n < 600; n++) begin
      bit v, st, fl, r;
      if (!last_stall || fl_prev) cur = gen_instr();
      v  = ($urandom_range(0, 7) != 0);
      st = ($urandom_range(0, 5) == 0);
      fl = ($urandom_range(0, 11) == 0);
      r  = ($urandom_range(0, 59) == 0);
      applyStimulus(v, cur, $urandom, st, fl, r);
      fl_prev = fl;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
